// File: rtl/tpu_pkg.sv
// Constants shared by the TPU core and its instruction ingress queue.
// Keeps the instruction width and NOP encoding in one place for both sides.
package tpu_pkg;

    localparam int INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

    // Opcode field; an all-zero opcode is the NOP the queue issues when empty
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam logic [OPC_MSB-OPC_LSB:0] OPC_NOP = '0;

    function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OPC_NOP;
    endfunction

endpackage

// File: rtl/strobe_edge.sv
// Rising-edge detector for the host load strobe: one-cycle pulse per 0->1 transition.
// Latency: pulse is combinational from sig_i against last cycle's registered value.
// Backpressure: none; a held-high strobe yields exactly one pulse.
module strobe_edge (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic pulse_o
);

    logic sig_q;

    // Keep tracking the pin during reset so a strobe already high at release
    // is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        sig_q <= sig_i;
    end

    assign pulse_o = sig_i & ~sig_q & ~rst;

endmodule

// File: rtl/instr_queue.sv
// Instruction ingress FIFO: strobe-loaded from pins, show-ahead valid/ready to the core.
// Latency: a word pushed at edge N is visible on out_instr/out_valid in cycle N+1.
// Backpressure: core_ready low holds the head; pushes into a full queue are dropped and flag overflow.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int INSTR_W = tpu_pkg::INSTR_W,
    parameter logic [INSTR_W-1:0] NOP_WORD = tpu_pkg::NOP_WORD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic                       in_strobe,
    input  logic                       clr_ovf,
    input  logic                       core_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic                       out_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push_req, push, pop, drop;

    strobe_edge u_strobe_edge (
        .clk     (clk),
        .rst     (rst),
        .sig_i   (in_strobe),
        .pulse_o (push_req)
    );

    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign out_valid = ~empty;
    assign out_instr = empty ? NOP_WORD : mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    // A pop at full frees the slot the same cycle, so the push still lands
    assign pop  = out_valid & core_ready;
    assign push = push_req & (~full | pop);
    assign drop = push_req & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        overflow_d = drop | (overflow_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: out_instr is masked by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Bench for instr_queue: directed vector table, hand sequences, then random traffic vs a queue model.
module tb_instr_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in_instr = '0;
    logic        in_strobe = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        core_ready = 1'b0;
    logic [15:0] out_instr;
    logic        out_valid;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: FIFO contents as a plain queue
    logic [15:0] mq[$];
    logic        m_ovf = 1'b0;
    logic        m_prev = 1'b0;
    logic [15:0] got[$];

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_instr   (in_instr),
        .in_strobe  (in_strobe),
        .clr_ovf    (clr_ovf),
        .core_ready (core_ready),
        .out_instr  (out_instr),
        .out_valid  (out_valid),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, s;
        logic [15:0] d;
        logic        c, k;
        logic [2:0]  cnt;
        logic        v;
        logic [15:0] o;
        logic        f, e, ov;
    } vec_t;

    vec_t tv[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic s, input logic [15:0] d,
                              input logic c, input logic k);
        logic req, pop, dropped;
        req = s & ~m_prev & ~r;
        m_prev = s;
        if (r) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop = (mq.size() > 0) && k;
            dropped = req && (mq.size() == DEPTH) && !pop;
            if (!dropped) begin
                if (pop) void'(mq.pop_front());
                if (req) mq.push_back(d);
            end
            m_ovf = dropped ? 1'b1 : (c ? 1'b0 : m_ovf);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic [15:0] d,
                        input logic c, input logic k);
        rst = r; in_strobe = s; in_instr = d; clr_ovf = c; core_ready = k;
        if (!r && out_valid && k) got.push_back(out_instr);
        model_edge(r, s, d, c, k);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [15:0] exp_o;
        exp_o = (mq.size() > 0) ? mq[0] : 16'h0000;
        check({tag, ".count"},    32'(count),     32'(mq.size()));
        check({tag, ".valid"},    32'(out_valid), 32'(mq.size() > 0));
        check({tag, ".instr"},    32'(out_instr), 32'(exp_o));
        check({tag, ".full"},     32'(full),      32'(mq.size() == DEPTH));
        check({tag, ".empty"},    32'(empty),     32'(mq.size() == 0));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    task automatic push_word(input logic [15:0] d);
        step(1'b0, 1'b1, d, 1'b0, 1'b0);
        step(1'b0, 1'b0, d, 1'b0, 1'b0);
    endtask

    task automatic check_got(input string tag, input logic [15:0] exp[$]);
        check({tag, ".len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    initial begin
        //            r     s     d         c     k     cnt   v     o         f     e     ov
        tv[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[1]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 16'h5555, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[3]  = '{1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[4]  = '{1'b0, 1'b1, 16'hA512, 1'b0, 1'b0, 3'd1, 1'b1, 16'hA512, 1'b0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        tv[6]  = '{1'b0, 1'b1, 16'h0101, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 16'h0202, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd2, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[10] = '{1'b0, 1'b1, 16'h0303, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd3, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b0};
        tv[12] = '{1'b0, 1'b1, 16'h0404, 1'b0, 1'b0, 3'd4, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0};
        tv[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd4, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0};
        tv[14] = '{1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0, 3'd4, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b1};
        tv[15] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 3'd4, 1'b1, 16'h0101, 1'b1, 1'b0, 1'b0};
        tv[16] = '{1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 3'd4, 1'b1, 16'h0202, 1'b1, 1'b0, 1'b0};

        for (int i = 0; i < 17; i++) begin
            step(tv[i].r, tv[i].s, tv[i].d, tv[i].c, tv[i].k);
            check($sformatf("v%0d.count", i),    32'(count),     32'(tv[i].cnt));
            check($sformatf("v%0d.valid", i),    32'(out_valid), 32'(tv[i].v));
            check($sformatf("v%0d.instr", i),    32'(out_instr), 32'(tv[i].o));
            check($sformatf("v%0d.full", i),     32'(full),      32'(tv[i].f));
            check($sformatf("v%0d.empty", i),    32'(empty),     32'(tv[i].e));
            check($sformatf("v%0d.overflow", i), 32'(overflow),  32'(tv[i].ov));
        end

        // BEEF went in behind the three survivors; DEAD must never appear
        got.delete();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_got("drain_beef", '{16'h0202, 16'h0303, 16'h0404, 16'hBEEF});
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_model("ready_when_empty");

        // Burst across the pointer wrap, with clear and drop colliding
        got.delete();
        push_word(16'h0101); push_word(16'h0202); push_word(16'h0303); push_word(16'h0404);
        check_model("burst_full");
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        push_word(16'h0505); push_word(16'h0606);
        step(1'b0, 1'b1, 16'hDEAD, 1'b1, 1'b0);
        check("drop_beats_clear", 32'(overflow), 32'd1);
        check_model("drop_clear");
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        check_got("wrap_order", '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 16'h0606});

        // Held strobe is a single push; reset discards queued words
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        check("held_strobe.count", 32'(count), 32'd1);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        push_word(16'hAAAA); push_word(16'hBBBB);
        check("pre_reset.count", 32'(count), 32'd3);
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        check("mid_reset.count", 32'(count), 32'd0);
        check("mid_reset.valid", 32'(out_valid), 32'd0);
        check("mid_reset.instr", 32'(out_instr), 32'h0000);
        check_model("post_reset");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), 16'($urandom),
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
